mem_bus_arb: RTL and testbench

MEM_BUS_ARB -- requirements
Module: mem_bus_arb

---
 rtl/mem_bus_pkg.sv | 19 +
 rtl/mem_bus_arb_prio_enc.sv | 20 ++
 rtl/mem_bus_arb.sv | 149 ++++++++++++++
 tb/tb_mem_bus_arb.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory/UART bus arbiter.
// Holds the FSM state encoding, default UART register addresses and UART status bit layout.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [15:0] UART_DATA_ADDR_DEF = 16'hBF00;
    localparam logic [15:0] UART_STAT_ADDR_DEF = 16'hBF01;

    // Bit positions inside the UART status word returned on a status read
    localparam int STAT_TXE_BIT = 0;
    localparam int STAT_RDY_BIT = 1;

endpackage

// File: rtl/mem_bus_arb_prio_enc.sv
// Fixed-priority one-hot grant: the lowest-index active request wins.
module prio_enc #(
    parameter int N_PORTS = 2
) (
    input  logic [N_PORTS-1:0] req,
    output logic [N_PORTS-1:0] gnt
);

    // Scan from the top down so the lowest active index is the last one written
    always_comb begin
        gnt = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arb.sv
// Arbitrates N request ports onto one asynchronous SRAM plus a memory-mapped UART.
// Each granted access runs IDLE -> SETUP -> ACCESS -> DONE; UART status reads short-cut to DONE.
module mem_bus_arb
    import mem_bus_pkg::*;
#(
    parameter int          N_PORTS        = 2,
    parameter int          DATA_W         = 16,
    parameter int          ADDR_W         = 18,
    parameter int          WAIT_CYC       = 2,
    parameter logic [15:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF,
    parameter logic [15:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF
) (
    input  logic                      Clk0,
    input  logic                      Rst,
    input  logic [N_PORTS-1:0]        req,
    input  logic [N_PORTS-1:0]        we,
    input  logic [N_PORTS*16-1:0]     addr,
    input  logic [N_PORTS*DATA_W-1:0] wdata,
    output logic [DATA_W-1:0]         rdata,
    output logic [N_PORTS-1:0]        ack,
    output logic                      stall,
    output logic                      ram_en,
    output logic                      ram_oe,
    output logic                      ram_we,
    output logic [ADDR_W-1:0]         ram_addr,
    inout  wire  [DATA_W-1:0]         ram_data,
    output logic                      rdn,
    output logic                      wrn,
    input  logic                      data_ready,
    input  logic                      tbre,
    input  logic                      tsre
);

    localparam int CNT_W = $clog2(WAIT_CYC + 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [N_PORTS-1:0] gnt, gnt_q;
    logic               sel_we, sel_stat, sel_uart;
    logic [15:0]        sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               we_q, sram_q, uart_q;
    logic [15:0]        addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               in_xfer, in_access, last_access, drive;

    function automatic logic [DATA_W-1:0] status_word(input logic rdy, input logic txe);
        logic [DATA_W-1:0] w;
        w               = '0;
        w[STAT_RDY_BIT] = rdy;
        w[STAT_TXE_BIT] = txe;
        return w;
    endfunction

    prio_enc #(.N_PORTS(N_PORTS)) u_prio_enc (
        .req (req),
        .gnt (gnt)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (gnt[i]) begin
                sel_we    = we[i];
                sel_addr  = addr[16*i +: 16];
                sel_wdata = wdata[DATA_W*i +: DATA_W];
            end
        end
    end

    assign sel_stat = (sel_addr == UART_STAT_ADDR);
    assign sel_uart = (sel_addr == UART_DATA_ADDR);

    always_ff @(posedge Clk0 or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (|req) state_nxt = sel_stat ? DONE : SETUP;
            end
            SETUP: begin
                cnt_nxt   = '0;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (cnt == CNT_W'(WAIT_CYC - 1)) state_nxt = DONE;
                else                             cnt_nxt   = cnt + CNT_W'(1);
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_xfer     = (state == SETUP) || (state == ACCESS) || (state == DONE);
    assign in_access   = (state == ACCESS);
    assign last_access = in_access && (cnt == CNT_W'(WAIT_CYC - 1));

    // Request attributes are frozen at grant so a port may change or drop its inputs mid-access
    always_ff @(posedge Clk0 or negedge Rst) begin
        if (!Rst) begin
            gnt_q   <= '0;
            we_q    <= 1'b0;
            sram_q  <= 1'b0;
            uart_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
        end else begin
            if (state == IDLE && |req) begin
                gnt_q   <= gnt;
                we_q    <= sel_we;
                sram_q  <= !sel_uart && !sel_stat;
                uart_q  <= sel_uart;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                if (sel_stat && !sel_we) rdata <= status_word(data_ready, tbre & tsre);
            end
            if (last_access && !we_q) rdata <= ram_data;
        end
    end

    assign ram_en   = !(in_xfer && sram_q);
    assign ram_oe   = !(in_access && sram_q && !we_q);
    assign ram_we   = !(in_access && sram_q && we_q);
    assign rdn      = !(in_access && uart_q && !we_q);
    assign wrn      = !(in_access && uart_q && we_q);
    assign ram_addr = ADDR_W'(addr_q);

    // Write data surrounds the strobe by one cycle on each side for hold/setup on the bus
    assign drive    = in_xfer && we_q && (sram_q || uart_q);
    assign ram_data = drive ? wdata_q : 'z;

    assign ack   = (state == DONE) ? gnt_q : '0;
    assign stall = |(req & ~ack);

endmodule

// File: tb/tb_mem_bus_arb.sv
// Self-checking bench for mem_bus_arb: table vectors, corner sequences and a randomized run.
module tb_mem_bus_arb;

    localparam int          NP    = 2;
    localparam int          DW    = 16;
    localparam int          AW    = 18;
    localparam int          WAIT  = 2;
    localparam logic [15:0] UDATA = 16'hBF00;
    localparam logic [15:0] USTAT = 16'hBF01;

    logic              Clk0 = 1'b0;
    logic              Rst  = 1'b0;
    logic [NP-1:0]     req  = '0;
    logic [NP-1:0]     we   = '0;
    logic [NP*16-1:0]  addr = '0;
    logic [NP*DW-1:0]  wdata = '0;
    logic [DW-1:0]     rdata;
    logic [NP-1:0]     ack;
    logic              stall;
    logic              ram_en, ram_oe, ram_we, rdn, wrn;
    logic [AW-1:0]     ram_addr;
    wire  [DW-1:0]     ram_data;
    logic              data_ready = 1'b0, tbre = 1'b0, tsre = 1'b0;

    mem_bus_arb #(
        .N_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .WAIT_CYC(WAIT),
        .UART_DATA_ADDR(UDATA), .UART_STAT_ADDR(USTAT)
    ) dut (
        .Clk0(Clk0), .Rst(Rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .stall(stall),
        .ram_en(ram_en), .ram_oe(ram_oe), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .rdn(rdn), .wrn(wrn),
        .data_ready(data_ready), .tbre(tbre), .tsre(tsre)
    );

    always #5 Clk0 = ~Clk0;

    function automatic logic [15:0] init_word(input int i);
        return (16'(i) * 16'h0101) ^ 16'h5A5A;
    endfunction

    // Device models: SRAM (1K words) and UART sharing the data bus
    logic [15:0] sram_mem [0:1023];
    logic [15:0] uart_tx;
    logic [7:0]  uart_rx = 8'h00;
    logic        bus_drv;
    logic [15:0] bus_val;

    always_comb begin
        bus_drv = (!ram_en && !ram_oe) || !rdn;
        bus_val = !rdn ? {8'h00, uart_rx} : sram_mem[ram_addr[9:0]];
    end
    assign ram_data = bus_drv ? bus_val : 'z;

    always @(posedge Clk0) begin
        if (!Rst) begin
            for (int i = 0; i < 1024; i++) sram_mem[i] <= init_word(i);
            uart_tx <= '0;
        end else begin
            if (!ram_en && !ram_we) sram_mem[ram_addr[9:0]] <= ram_data;
            if (!wrn) uart_tx <= ram_data;
        end
    end

    // Reference model state
    logic [15:0] ref_mem [0:1023];
    logic [15:0] exp_rdata;
    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] strobes;
    assign strobes = {ram_en, ram_oe, ram_we, rdn, wrn};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        exp_rdata = '0;
    endtask

    // kind: 0 = SRAM, 1 = UART data register, 2 = UART status register
    function automatic int kind_of(input logic [15:0] a);
        if (a == USTAT) return 2;
        if (a == UDATA) return 1;
        return 0;
    endfunction

    // Strobe pattern expected k cycles after the request was sampled, for an access of latency L
    function automatic logic [4:0] exp_strobes(input int kind, input logic w, input int k, input int L);
        logic en, oe, wen, rd, wr;
        logic mid;
        en = 1'b1; oe = 1'b1; wen = 1'b1; rd = 1'b1; wr = 1'b1;
        mid = (k >= 2) && (k <= L - 1);
        if (kind == 0) begin
            en  = !(k >= 1 && k <= L);
            oe  = !(!w && mid);
            wen = !(w && mid);
        end else if (kind == 1) begin
            rd = !(!w && mid);
            wr = !(w && mid);
        end
        return {en, oe, wen, rd, wr};
    endfunction

    // Runs one single-port access starting just after a rising edge; returns with req dropped
    task automatic run_txn(input int port, input logic w, input logic [15:0] a, input logic [15:0] d,
                           input logic dr, input logic tbv, input logic tsv, input logic [7:0] rx,
                           input string tag);
        int          kind, L, k;
        logic [NP-1:0] one;
        kind = kind_of(a);
        L    = (kind == 2) ? 1 : WAIT + 2;
        one  = '0;
        one[port] = 1'b1;
        if (!w) begin
            if (kind == 2)      exp_rdata = {14'h0, dr, tbv & tsv};
            else if (kind == 1) exp_rdata = {8'h00, rx};
            else                exp_rdata = ref_mem[a[9:0]];
        end else if (kind == 0) begin
            ref_mem[a[9:0]] = d;
        end
        uart_rx    = rx;
        data_ready = dr; tbre = tbv; tsre = tsv;
        we[port]   = w;
        addr[16*port +: 16]  = a;
        wdata[DW*port +: DW] = d;
        req[port]  = 1'b1;
        for (k = 0; k <= L; k++) begin
            @(negedge Clk0);
            check($sformatf("%s strobes k%0d", tag, k), 32'(strobes), 32'(exp_strobes(kind, w, k, L)));
            check($sformatf("%s ack k%0d", tag, k), 32'(ack), (k == L) ? 32'(one) : 32'd0);
            check($sformatf("%s stall k%0d", tag, k), 32'(stall), (k < L) ? 32'd1 : 32'd0);
            if (kind == 0 && k >= 1)
                check($sformatf("%s ram_addr k%0d", tag, k), 32'(ram_addr), 32'(a));
            if (k == L)
                check($sformatf("%s rdata", tag), 32'(rdata), 32'(exp_rdata));
            @(posedge Clk0);
            #1;
        end
        req[port] = 1'b0;
        if (w && kind == 0) check($sformatf("%s sram contents", tag), 32'(sram_mem[a[9:0]]), 32'(d));
        if (w && kind == 1) check($sformatf("%s uart tx", tag), 32'(uart_tx), 32'(d));
    endtask

    typedef struct {
        int          port;
        logic        w;
        logic [15:0] a;
        logic [15:0] d;
        logic        dr, tbv, tsv;
        logic [7:0]  rx;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000};
        vecs[1] = '{1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'hBEEF};
        vecs[2] = '{0, 1'b0, 16'hBF01, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00, 16'h0002};
        vecs[3] = '{1, 1'b0, 16'hBF01, 16'h0000, 1'b0, 1'b1, 1'b1, 8'h00, 16'h0001};
        vecs[4] = '{0, 1'b1, 16'hBF00, 16'h0041, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0001};
        vecs[5] = '{1, 1'b0, 16'hBF00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h5A, 16'h005A};
        vecs[6] = '{0, 1'b1, 16'hBF01, 16'hFFFF, 1'b1, 1'b1, 1'b1, 8'h00, 16'h005A};
        vecs[7] = '{1, 1'b1, 16'h0011, 16'hC3C3, 1'b0, 1'b0, 1'b0, 8'h00, 16'h005A};
        vecs[8] = '{0, 1'b0, 16'h0011, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'hC3C3};

        model_reset();
        #1;
        check("reset ack", 32'(ack), 32'd0);
        check("reset rdata", 32'(rdata), 32'd0);
        check("reset strobes", 32'(strobes), 32'h1F);
        check("reset ram_addr", 32'(ram_addr), 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        repeat (2) @(posedge Clk0);
        #1;
        Rst = 1'b1;
        @(posedge Clk0);
        #1;

        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].port, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].dr, vecs[i].tbv,
                    vecs[i].tsv, vecs[i].rx, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table rdata", i), 32'(rdata), 32'(vecs[i].exp_rd));
        end

        // Both ports request together: port 0 first, port 1 re-arbitrated in the following IDLE
        we = 2'b10; we[0] = 1'b1;
        we[1] = 1'b0;
        addr[15:0]  = 16'h0020; addr[31:16]  = 16'h0020;
        wdata[15:0] = 16'h1234; wdata[31:16] = 16'h0000;
        req = 2'b11;
        ref_mem[16'h0020] = 16'h1234;
        exp_rdata = 16'h1234;
        for (int k = 0; k <= 11; k++) begin
            @(negedge Clk0);
            check($sformatf("dual ack k%0d", k), 32'(ack),
                  (k == 4) ? 32'd1 : (k == 9) ? 32'd2 : 32'd0);
            check($sformatf("dual stall k%0d", k), 32'(stall), (k <= 8) ? 32'd1 : 32'd0);
            if (k == 9) check("dual rdata", 32'(rdata), 32'h1234);
            @(posedge Clk0);
            #1;
            if (k == 4) req[0] = 1'b0;
            if (k == 9) req[1] = 1'b0;
        end

        // Reset during ACCESS of an SRAM write: everything released at once, no ack
        we[0] = 1'b1; addr[15:0] = 16'h0030; wdata[15:0] = 16'h7777;
        req[0] = 1'b1;
        repeat (2) begin
            @(posedge Clk0);
            #1;
        end
        @(negedge Clk0);
        check("pre-reset ram_we", 32'(ram_we), 32'd0);
        #1;
        Rst = 1'b0;
        #1;
        check("midreset strobes", 32'(strobes), 32'h1F);
        check("midreset ack", 32'(ack), 32'd0);
        check("midreset rdata", 32'(rdata), 32'd0);
        check("midreset ram_addr", 32'(ram_addr), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk0);
            check($sformatf("in-reset ack k%0d", k), 32'(ack), 32'd0);
        end
        @(posedge Clk0);
        #1;
        req = '0;
        model_reset();
        Rst = 1'b1;
        @(posedge Clk0);
        #1;
        run_txn(1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, "post-reset");

        // Randomized single-port traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            int          sel, port;
            logic        w;
            logic [15:0] a;
            sel  = int'($urandom_range(0, 9));
            port = int'($urandom_range(0, NP - 1));
            w    = 1'($urandom_range(0, 1));
            if (sel < 7)      a = 16'($urandom_range(0, 31));
            else if (sel < 8) a = UDATA;
            else              a = USTAT;
            run_txn(port, w, a, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    8'($urandom), $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
